// File: rtl/tank_level_ctrl.sv
// Tank level controller: probe sync/debounce, fill/outlet valve FSM, fault alarm and display scan clock.
// Optional macro TANK_FILL_TIMEOUT_EN adds a FILL watchdog that faults if MID is not reached in FILL_TIMEOUT cycles.
module tank_level_ctrl #(
    parameter int DEB_CYCLES     = 4,
    parameter int MIN_OFF_CYCLES = 8,
    parameter int SCAN_DIV       = 4,
    parameter int FILL_TIMEOUT   = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic probe_l,
    input  logic probe_m,
    input  logic probe_h,
    input  logic demand,
    input  logic alarm_ack,
    output logic L,
    output logic M,
    output logic H,
    output logic Alarm,
    output logic sinal_A,
    output logic sinal_G,
    output logic delay
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_HOLD    = 2'd1,
        ST_FILL    = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    localparam logic [7:0] DEB_LAST     = 8'(DEB_CYCLES - 1);
    localparam logic [8:0] STARTUP_LAST = 9'(DEB_CYCLES + 1);
    localparam logic [7:0] MIN_OFF_LOAD = 8'(MIN_OFF_CYCLES);
    localparam logic [7:0] SCAN_LAST    = 8'(SCAN_DIV - 1);

    // bit 0 = low, bit 1 = mid, bit 2 = high
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      deb_q, deb_d;
    logic [2:0][7:0] deb_cnt_q, deb_cnt_d;
    state_e          state_q, state_d, fsm_next_s;
    logic [8:0]      start_cnt_q, start_cnt_d;
    logic [7:0]      min_off_q, min_off_d;
    logic [7:0]      scan_cnt_q, scan_cnt_d;
    logic            delay_q, delay_d;
    logic            a_q, a_d, g_q, g_d, alarm_q, alarm_d;
    logic            code_valid_s, code_low_s, code_mid_s, code_high_s;

`ifdef TANK_FILL_TIMEOUT_EN
    localparam logic [31:0] FILL_LAST = 32'(FILL_TIMEOUT - 1);
    logic [31:0] fill_cnt_q, fill_cnt_d;
`else
    logic fill_timeout_unused_s;
    assign fill_timeout_unused_s = (FILL_TIMEOUT != 32'sd0);
`endif

    // Per-probe debounce: output follows sync only after DEB_CYCLES consecutive differing cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = 8'd0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
                end
            end else begin
                deb_cnt_d[i] = 8'd0;
            end
        end
    end

    // Classify debounced level code {H,M,L}.
    always_comb begin
        code_valid_s = 1'b0;
        code_low_s   = 1'b0;
        code_mid_s   = 1'b0;
        code_high_s  = 1'b0;
        case (deb_q)
            3'b000, 3'b001: begin
                code_valid_s = 1'b1;
                code_low_s   = 1'b1;
            end
            3'b011: begin
                code_valid_s = 1'b1;
                code_mid_s   = 1'b1;
            end
            3'b111: begin
                code_valid_s = 1'b1;
                code_mid_s   = 1'b1;
                code_high_s  = 1'b1;
            end
            default: code_valid_s = 1'b0;
        endcase
    end

    // Valve FSM next state; an invalid code forces FAULT over any other transition.
    always_comb begin
        fsm_next_s  = state_q;
        start_cnt_d = start_cnt_q;
`ifdef TANK_FILL_TIMEOUT_EN
        fill_cnt_d  = 32'd0;
`endif
        case (state_q)
            ST_STARTUP: begin
                if (start_cnt_q == STARTUP_LAST) begin
                    fsm_next_s  = ST_HOLD;
                    start_cnt_d = 9'd0;
                end else begin
                    start_cnt_d = start_cnt_q + 9'd1;
                end
            end
            ST_HOLD: begin
                if (code_low_s && (min_off_q == 8'd0)) begin
                    fsm_next_s = ST_FILL;
                end else begin
                    fsm_next_s = ST_HOLD;
                end
            end
            ST_FILL: begin
                if (code_high_s) begin
                    fsm_next_s = ST_HOLD;
                end else begin
                    fsm_next_s = ST_FILL;
`ifdef TANK_FILL_TIMEOUT_EN
                    if (code_mid_s) begin
                        fill_cnt_d = 32'd0;
                    end else if (fill_cnt_q == FILL_LAST) begin
                        fsm_next_s = ST_FAULT;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 32'd1;
                    end
`endif
                end
            end
            ST_FAULT: begin
                if (alarm_ack && code_valid_s) begin
                    fsm_next_s = ST_HOLD;
                end else begin
                    fsm_next_s = ST_FAULT;
                end
            end
            default: fsm_next_s = ST_FAULT;
        endcase
        state_d = code_valid_s ? fsm_next_s : ST_FAULT;
    end

    // Registered outputs from next state, min-off hold-off and scan divider.
    always_comb begin
        a_d     = (state_d == ST_FILL);
        alarm_d = (state_d == ST_FAULT);
        g_d     = (state_d == ST_HOLD) && demand && code_mid_s;
        if (a_q && !a_d) begin
            min_off_d = MIN_OFF_LOAD;
        end else if (min_off_q != 8'd0) begin
            min_off_d = min_off_q - 8'd1;
        end else begin
            min_off_d = 8'd0;
        end
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = 8'd0;
            delay_d    = ~delay_q;
        end else begin
            scan_cnt_d = scan_cnt_q + 8'd1;
            delay_d    = delay_q;
        end
    end

    // State register; async reset drops both valves immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            deb_q       <= 3'b000;
            deb_cnt_q   <= '0;
            state_q     <= ST_STARTUP;
            start_cnt_q <= 9'd0;
            min_off_q   <= 8'd0;
            scan_cnt_q  <= 8'd0;
            delay_q     <= 1'b0;
            a_q         <= 1'b0;
            g_q         <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef TANK_FILL_TIMEOUT_EN
            fill_cnt_q  <= 32'd0;
`endif
        end else begin
            sync1_q     <= {probe_h, probe_m, probe_l};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            min_off_q   <= min_off_d;
            scan_cnt_q  <= scan_cnt_d;
            delay_q     <= delay_d;
            a_q         <= a_d;
            g_q         <= g_d;
            alarm_q     <= alarm_d;
`ifdef TANK_FILL_TIMEOUT_EN
            fill_cnt_q  <= fill_cnt_d;
`endif
        end
    end

    assign L       = deb_q[0];
    assign M       = deb_q[1];
    assign H       = deb_q[2];
    assign Alarm   = alarm_q;
    assign sinal_A = a_q;
    assign sinal_G = g_q;
    assign delay   = delay_q;

endmodule

// File: doc/tank_level_ctrl.md
Name: tank_level_ctrl

Overview:
Upstream control stage for the tank display matrices. It takes the raw level probes (low/mid/high), the consumer demand and the alarm acknowledge. It produces the debounced L/M/H levels and Alarm for the level matrix, and the fill-valve (sinal_A) and outlet-valve (sinal_G) commands for the actuator matrix. It also generates the matrix scan clock `delay`.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronised probe must differ from its debounced value before that value updates. Range 1..255.
- MIN_OFF_CYCLES, 8: minimum cycles sinal_A must stay 0 after deasserting, before it may reassert. Range 1..255.
- SCAN_DIV, 4: `delay` toggles every SCAN_DIV cycles, giving a period of 2*SCAN_DIV cycles. Range 1..255.
- FILL_TIMEOUT, 1024: maximum FILL duration without reaching the mid level. Used only with the optional feature.

Ports:
- clk, in, 1: system clock. All state updates on the rising edge.
- rstn, in, 1: asynchronous, active-low reset.
- probe_l, in, 1: raw low-level probe. Asynchronous; 1 = wet.
- probe_m, in, 1: raw mid-level probe. Asynchronous.
- probe_h, in, 1: raw high-level probe. Asynchronous.
- demand, in, 1: consumer requests outflow. Synchronous.
- alarm_ack, in, 1: operator acknowledge. One-cycle pulse or held.
- L, out, 1: debounced low-level probe.
- M, out, 1: debounced mid-level probe.
- H, out, 1: debounced high-level probe.
- Alarm, out, 1: fault indication.
- sinal_A, out, 1: fill valve open.
- sinal_G, out, 1: outlet valve open.
- delay, out, 1: display scan clock, 50% duty.

Behaviour:
- Reset (rstn=0, asynchronous): L=M=H=0, Alarm=0, sinal_A=0, sinal_G=0, delay=0. All counters 0; state=STARTUP. Reset mid-operation closes both valves immediately, without waiting for a clock.
- Input sync: each probe passes through a 2-FF synchroniser.
- Debounce, per probe: counter clears whenever sync==debounced. It increments while they differ. When the count reaches DEB_CYCLES, the debounced output takes the sync value and the counter clears.
  - Latency: a raw step held stable is visible on L/M/H exactly 2+DEB_CYCLES edges later.
  - Glitches shorter than DEB_CYCLES cycles never reach the outputs.
- Level code {H,M,L}:
  - Valid codes: 000 EMPTY, 001 LOW, 011 MID, 111 HIGH.
  - Any other code is INVALID.
- FSM (Moore; valve/Alarm outputs decoded from registered state, so they change on the edge after the debounced code changes):
  - STARTUP: wait 2+DEB_CYCLES cycles, then go to HOLD. Valves 0.
  - HOLD: A=0. G=demand AND code in {MID,HIGH}.
    - Go to FILL if code in {EMPTY,LOW} and the min-off counter has expired.
  - FILL: A=1, G=0 (fill has priority over demand).
    - Go to HOLD when code==HIGH.
  - FAULT: A=0, G=0, Alarm=1.
    - Go to HOLD only when alarm_ack=1 and the current code is valid, both in the same cycle. Otherwise stay.
  - From any state, code==INVALID → FAULT on the next edge. This overrides every other transition.
- Min-off counter: loads MIN_OFF_CYCLES on any edge where sinal_A goes 1→0, including entry to FAULT. It decrements to 0 and saturates there. HOLD→FILL is blocked while it is nonzero.
- Scan divider: counter runs 0..SCAN_DIV-1. `delay` toggles on the wrap edge. It free-runs in every state, including FAULT.
- Simultaneous events:
  - INVALID with alarm_ack: stay in FAULT.
  - HIGH reached in the same cycle as INVALID: FAULT wins.
- sinal_A and sinal_G are never 1 in the same cycle.

Optional Feature:
- Macro: TANK_FILL_TIMEOUT_EN.
- Defined: a counter clears on FILL entry and increments each FILL cycle. It clears when code reaches MID.
  - If it reaches FILL_TIMEOUT before MID, go to FAULT: Alarm=1, valve closed, min-off loaded.
  - Exit from FAULT uses the normal ack rule.
- Undefined: no counter is built, FILL_TIMEOUT is ignored, and FILL may last indefinitely.

Test Plan:
- Reset: hold rstn=0 with all probes=1 → all outputs 0. Release → state stays STARTUP for 6 cycles, HOLD entered on cycle 6. Probes all 1 → HOLD with A=0.
- Debounce: probe_l pulses 1 for 3 cycles → L stays 0. Held 1 → L=1 exactly 6 edges after the step. Then sinal_A=1 on the next edge and sinal_G=0 even with demand=1.
- Fill cycle: from LOW, raise M then H (each held) → A=1 until code 111, A=0 on the edge after H rises. Drop to 001 at 3 cycles after A fell → A stays 0 until 8 cycles after the fall, then A=1.
- Outflow: code 011, demand=1 in HOLD → G=1. demand=0 → G=0 on the next edge.
- Fault: debounced code 101 → Alarm=1, A=G=0 one edge later. ack while code still 101 → stay FAULT. Code 111 plus ack → Alarm=0, HOLD.
- Scan clock and macro: with SCAN_DIV=4 → `delay` period 8 cycles in all states. With TANK_FILL_TIMEOUT_EN and FILL_TIMEOUT=16, code stuck at 001 → Alarm=1 after 16 FILL cycles. Without the macro → A stays 1.
